// File: rtl/cpu_pkg.sv
// Shared definitions for the instruction issue unit: encodings, the
// legality check and the issue FSM state type.
package cpu_pkg;

  localparam int INSTR_W = 16;

  localparam logic [2:0] OPC_MOV = 3'b110;
  localparam logic [2:0] OPC_ALU = 3'b101;
  localparam logic [1:0] OP_IMM  = 2'b10;
  localparam logic [1:0] OP_REG  = 2'b00;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    EXEC  = 2'd2,
    HALT  = 2'd3
  } issue_state_t;

  // MOV supports only the immediate and register forms; every ALU op is legal.
  function automatic logic is_legal_instr(input logic [INSTR_W-1:0] instr);
    logic [2:0] opc;
    logic [1:0] op;
    logic       legal;
    opc   = instr[15:13];
    op    = instr[12:11];
    legal = 1'b0;
    if (opc == OPC_ALU) begin
      legal = 1'b1;
    end else if (opc == OPC_MOV) begin
      legal = (op == OP_IMM) || (op == OP_REG);
    end
    return legal;
  endfunction

endpackage

// File: rtl/instr_fifo.sv
// Circular instruction buffer. DEPTH must be a power of two so the
// read/write pointers wrap by plain overflow. Push is ignored when full,
// pop is ignored when empty; push and pop together leave the count unchanged.
module instr_fifo
  import cpu_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CNTW  = $clog2(DEPTH) + 1
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_push,
  input  logic [INSTR_W-1:0] i_wdata,
  input  logic               i_pop,
  output logic [INSTR_W-1:0] o_rdata,
  output logic [CNTW-1:0]    o_count,
  output logic               o_full,
  output logic               o_empty
);

  logic [INSTR_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]      r_wptr;
  logic [AW-1:0]      r_rptr;
  logic [CNTW-1:0]    r_count;
  logic               w_push;
  logic               w_pop;

  assign o_full  = (r_count == CNTW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_rdata = r_mem[r_rptr];
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  // Storage array: written at the write pointer, no reset needed.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= i_wdata;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNTW'(1);
        2'b01:   r_count <= r_count - CNTW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/instr_issue_unit.sv
// Issues buffered instructions to the controller over the s/w start
// handshake. Handshake: the unit raises s while in START; the controller
// accepts by dropping w (s falls the next cycle) and retires by raising
// w again. Illegal encodings are popped and discarded without issue.
module instr_issue_unit
  import cpu_pkg::*;
#(
  parameter  int DEPTH   = 4,
  parameter  int CW      = 8,
  parameter  int TIMEOUT = 16,
  localparam int CNTW    = $clog2(DEPTH) + 1,
  localparam int TW      = $clog2(TIMEOUT + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic               w,
  output logic               s,
  output logic [INSTR_W-1:0] instr,
  output logic [2:0]         opcode,
  output logic [1:0]         op,
  output logic [CNTW-1:0]    fifo_cnt,
  output logic [CW-1:0]      retired,
  output logic [CW-1:0]      dropped,
  output logic               illegal,
  output logic               err,
  output logic [1:0]         state_dbg
);

  issue_state_t       r_state;
  issue_state_t       w_next;
  logic [INSTR_W-1:0] r_ir;
  logic [TW-1:0]      r_tmo;
  logic [CW-1:0]      r_retired;
  logic [CW-1:0]      r_dropped;
  logic               r_err;
  logic [INSTR_W-1:0] w_head;
  logic               w_empty;
  logic               w_full;
  logic               w_pop;
  logic               w_head_legal;
  logic               w_tmo_hit;

  instr_fifo #(.DEPTH(DEPTH)) u_fifo (
    .i_clk   (clk),
    .i_rst_n (reset),
    .i_push  (in_valid),
    .i_wdata (in_instr),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_count (fifo_cnt),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign w_head_legal = is_legal_instr(w_head);
  // The TIMEOUT-th consecutive START cycle with w still high trips the error.
  assign w_tmo_hit    = (r_tmo == TW'(TIMEOUT - 1));

  assign in_ready  = !w_full;
  assign instr     = r_ir;
  assign opcode    = r_ir[15:13];
  assign op        = r_ir[12:11];
  assign retired   = r_retired;
  assign dropped   = r_dropped;
  assign err       = r_err;
  assign state_dbg = r_state;

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // FSM next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_pop && w_head_legal) w_next = START;
      START:   if (!w) w_next = EXEC;
               else if (w_tmo_hit) w_next = HALT;
      EXEC:    if (w) w_next = IDLE;
      HALT:    w_next = HALT;
      default: w_next = IDLE;
    endcase
  end

  // FSM outputs: start request, FIFO pop and the drop pulse.
  always_comb begin
    s       = 1'b0;
    w_pop   = 1'b0;
    illegal = 1'b0;
    case (r_state)
      IDLE: begin
        w_pop   = !w_empty && w;
        illegal = !w_empty && w && !w_head_legal;
      end
      START:   s = 1'b1;
      default: s = 1'b0;
    endcase
  end

  // Instruction register: loads only on a legal pop, so it holds through retire.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                     r_ir <= '0;
    else if (w_pop && w_head_legal) r_ir <= w_head;
  end

  // Timeout counter (zero outside START) and sticky error flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tmo <= '0;
      r_err <= 1'b0;
    end else if (r_state != START) begin
      r_tmo <= '0;
    end else if (w) begin
      r_tmo <= r_tmo + TW'(1);
      if (w_tmo_hit) r_err <= 1'b1;
    end
  end

  // Saturating retired/dropped statistics.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_retired <= '0;
      r_dropped <= '0;
    end else begin
      if ((r_state == EXEC) && w && !(&r_retired)) r_retired <= r_retired + CW'(1);
      if (illegal && !(&r_dropped))                r_dropped <= r_dropped + CW'(1);
    end
  end

endmodule
